// File: rtl/note_pkg.sv
// Shared note definitions for the tone generator and the mic-side recognizer.
// Holds the 100x frequency table, the half-period helper and the player FSM states.
package note_pkg;

    typedef logic [3:0] note_idx_t;

    typedef enum logic [3:0] {
        N_E, N_F, N_FS, N_G, N_GS, N_A, N_AS, N_B, N_C, N_CS, N_D, N_DS
    } note_name_t;

    localparam int NUM_NOTES = 12;

    localparam int FREQ_100 [NUM_NOTES] = '{
        8241, 8731, 9250, 9800, 10383, 11000,
        11654, 12347, 13081, 13859, 14683, 15556
    };

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

    // Clock cycles per half period of the base-octave note (frequency is stored x100).
    function automatic logic [19:0] half_period(input int clk_mhz, input int idx);
        longint num;
        longint den;
        num = longint'(clk_mhz) * 64'sd100_000_000;
        den = 2 * longint'(FREQ_100[idx]);
        return 20'(num / den);
    endfunction

endpackage

// File: rtl/env_tick_gen.sv
// 1 ms tick for the envelope: o_tick is combinational, high in the last cycle of each ms.
// Counts only while i_en; i_clr restarts the millisecond synchronously. No backpressure.
module env_tick_gen #(
    parameter int CLK_MHZ = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int TICK_MAX = CLK_MHZ * 1000 - 1;
    localparam int W        = $clog2(CLK_MHZ * 1000);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt == W'(TICK_MAX));
    assign o_tick = i_en && !i_clr && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave note player with linear attack/sustain/release envelope on a signed 16-bit output.
// Sound is registered (1-cycle latency after amp/sign); note_ready is low for the whole note.
module note_tone_gen
    import note_pkg::*;
#(
    parameter int clk_mhz  = 50,
    parameter int amp_max  = 8192,
    parameter int env_step = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [3:0]  note_idx,
    input  logic [1:0]  octave,
    input  logic [9:0]  duration_ms,
    input  logic        stop,
    output logic [15:0] sound,
    output logic        busy,
    output logic        done,
    output logic        bad_note
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_amp;
    logic [15:0] w_amp_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_bad;
    logic [15:0] r_sound;
    logic [19:0] r_half;
    logic [19:0] r_phase;
    logic        r_sign;
    logic [9:0]  r_dur;
    logic [9:0]  r_ms;

    logic        w_accept;
    logic        w_valid_idx;
    logic        w_load;
    logic        w_tick;
    logic        w_release_req;
    logic [1:0]  w_shift;
    logic [16:0] w_amp_up;
    logic [19:0] w_half_sel;
    logic [19:0] w_half_tbl [NUM_NOTES];

    for (genvar g = 0; g < NUM_NOTES; g++) begin : g_half
        assign w_half_tbl[g] = half_period(clk_mhz, g);
    end

    always_comb begin
        w_half_sel = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (note_idx == 4'(i)) w_half_sel = w_half_tbl[i];
        end
    end

    assign note_ready    = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign bad_note      = r_bad;
    assign sound         = r_sound;
    assign w_accept      = note_valid && note_ready;
    assign w_valid_idx   = (note_idx < 4'(NUM_NOTES));
    assign w_load        = w_accept && w_valid_idx;
    assign w_shift       = (octave == 2'd3) ? 2'd2 : octave;
    assign w_release_req = (r_ms == r_dur) || stop;
    assign w_amp_up      = {1'b0, r_amp} + 17'(env_step);

    env_tick_gen #(
        .CLK_MHZ (clk_mhz)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state != IDLE),
        .i_clr  (w_load),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_amp_nxt   = r_amp;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = ATTACK;
                    w_amp_nxt   = '0;
                end
            end
            ATTACK: begin
                // Release takes priority over a coincident envelope tick.
                if (w_release_req) begin
                    w_state_nxt = RELEASE;
                end else begin
                    if (w_tick) begin
                        w_amp_nxt = (w_amp_up >= 17'(amp_max)) ? 16'(amp_max) : w_amp_up[15:0];
                    end
                    if (r_amp == 16'(amp_max)) w_state_nxt = SUSTAIN;
                end
            end
            SUSTAIN: begin
                if (w_release_req) w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (r_amp == '0) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_tick) begin
                    w_amp_nxt = (r_amp <= 16'(env_step)) ? '0 : r_amp - 16'(env_step);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_amp   <= '0;
            r_done  <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_amp   <= w_amp_nxt;
            r_done  <= w_done_nxt;
            r_bad   <= w_accept && !w_valid_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sound <= '0;
            r_half  <= '0;
            r_phase <= '0;
            r_sign  <= 1'b0;
            r_dur   <= '0;
            r_ms    <= '0;
        end else begin
            r_sound <= (r_state == IDLE) ? '0 : (r_sign ? r_amp : -r_amp);
            if (w_load) begin
                r_half  <= w_half_sel >> w_shift;
                r_dur   <= duration_ms;
                r_phase <= '0;
                r_sign  <= 1'b1;
                r_ms    <= '0;
            end else if (r_state != IDLE) begin
                if (r_phase == r_half - 20'd1) begin
                    r_phase <= '0;
                    r_sign  <= ~r_sign;
                end else begin
                    r_phase <= r_phase + 20'd1;
                end
                if (w_tick) r_ms <= r_ms + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen at 1 MHz: expected samples are hand-derived from
// cycle offsets after the accepting edge (sound at offset m reflects sign/amp at m-1).
module tb_note_tone_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic [3:0]  note_idx = '0;
    logic [1:0]  octave = '0;
    logic [9:0]  duration_ms = '0;
    logic        stop = 1'b0;
    logic [15:0] sound;
    logic        busy;
    logic        done;
    logic        bad_note;

    int checks = 0;
    int fails  = 0;
    int cur    = 0;
    int seen_done;

    always #5 clk = ~clk;

    note_tone_gen #(
        .clk_mhz  (1),
        .amp_max  (8192),
        .env_step (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_idx    (note_idx),
        .octave      (octave),
        .duration_ms (duration_ms),
        .stop        (stop),
        .sound       (sound),
        .busy        (busy),
        .done        (done),
        .bad_note    (bad_note)
    );

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to(input int m);
        adv(m - cur);
        cur = m;
    endtask

    task automatic request(input logic [3:0] idx, input logic [1:0] oct,
                           input logic [9:0] dur, input bit hold);
        note_idx    = idx;
        octave      = oct;
        duration_ms = dur;
        note_valid  = 1'b1;
        adv(1);
        cur = 0;
        if (!hold) note_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int s(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    initial begin
        adv(2);
        chk("rst_sound", s(sound), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bad", int'(bad_note), 0);
        chk("rst_ready", int'(note_ready), 1);
        rst = 1'b0;
        adv(1);

        // A, octave 0, 20 ms, note_valid held high throughout: half = 4545
        request(4'd5, 2'd0, 10'd20, 1'b1);
        chk("a_busy", int'(busy), 1);
        chk("a_ready_low", int'(note_ready), 0);
        to(1);    chk("a_start_zero", s(sound), 0);
        to(1001); chk("a_amp1", s(sound), 1024);
        to(4545); chk("a_pre_toggle", s(sound), 4096);
        to(4546); chk("a_post_toggle", s(sound), -4096);
        to(8000); chk("a_amp7", s(sound), -7168);
        to(8001); chk("a_amp_max", s(sound), -8192);
        to(9091); chk("a_sustain", s(sound), 8192);
        to(21000); chk("a_rel_hold", s(sound), 8192);
        to(21001); chk("a_rel_step", s(sound), 7168);
        to(27000); duration_ms = 10'd0;
        to(28000); chk("a_done_early", int'(done), 0);
        chk("a_busy_late", int'(busy), 1);
        to(28001); chk("a_done", int'(done), 1);
        chk("a_sound_end", s(sound), 0);
        // Held request re-accepted one cycle after done, with duration 0
        to(28002); chk("b_accept", int'(busy), 1);
        chk("b_done_once", int'(done), 0);
        note_valid = 1'b0;
        to(28003); chk("b_sound0", s(sound), 0);
        to(28004); chk("b_done", int'(done), 1);
        chk("b_idle", int'(busy), 0);
        to(28005); chk("b_done_clr", int'(done), 0);
        chk("b_ready", int'(note_ready), 1);

        // E, octave 2: half = 1516; stop at 3 ms forces release
        request(4'd0, 2'd2, 10'd5, 1'b0);
        to(1516); chk("e2_pre_toggle", s(sound), 1024);
        to(1517); chk("e2_post_toggle", s(sound), -1024);
        to(3032); chk("e2_amp3_neg", s(sound), -3072);
        to(3033); chk("e2_amp3_pos", s(sound), 3072);
        stop = 1'b1;
        to(3034); stop = 1'b0;
        to(3035); chk("e2_stop_hold", s(sound), 3072);
        to(4001); chk("e2_rel_step", s(sound), 2048);
        to(6000); chk("e2_done_early", int'(done), 0);
        to(6001); chk("e2_done", int'(done), 1);
        to(6002); chk("e2_idle", int'(busy), 0);

        // E, octave 3 behaves as octave 2; reset while sustaining
        request(4'd0, 2'd3, 10'd12, 1'b0);
        to(1516); chk("e3_pre_toggle", s(sound), 1024);
        to(1517); chk("e3_post_toggle", s(sound), -1024);
        to(9000); chk("e3_sustain", s(sound), -8192);
        rst = 1'b1;
        to(9001);
        chk("rst_mid_sound", s(sound), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(note_ready), 1);
        chk("rst_mid_done", int'(done), 0);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            adv(1);
            if (done) seen_done++;
        end
        chk("rst_no_done", seen_done, 0);

        // Duration 0: done within two cycles, silent throughout
        request(4'd8, 2'd1, 10'd0, 1'b0);
        chk("d0_busy", int'(busy), 1);
        to(1); chk("d0_sound1", s(sound), 0);
        chk("d0_done1", int'(done), 0);
        to(2); chk("d0_done", int'(done), 1);
        chk("d0_sound2", s(sound), 0);
        to(3); chk("d0_sound3", s(sound), 0);
        chk("d0_ready", int'(note_ready), 1);

        // Invalid index 13
        request(4'd13, 2'd0, 10'd5, 1'b0);
        chk("bad_pulse", int'(bad_note), 1);
        chk("bad_busy", int'(busy), 0);
        chk("bad_done", int'(done), 0);
        to(1); chk("bad_clr", int'(bad_note), 0);
        chk("bad_busy2", int'(busy), 0);
        chk("bad_sound", s(sound), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
